// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; optional MULDIV_EARLY_OUT_EN
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            div_by_zero
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mag_q, mag_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              qsign_q, qsign_d;
    logic              rsign_q, rsign_d;
    logic              dbz_q, dbz_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;
    logic              div_by_zero_q, div_by_zero_d;

    logic              in_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     div_rem_w, div_trial;
    logic [2*XLEN-1:0] div_step;
    logic              fix_signed;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;

    assign in_signed = ~op[0];
    assign a_neg     = in_signed & operand_a[XLEN-1];
    assign b_neg     = in_signed & operand_b[XLEN-1];
    assign a_mag     = a_neg ? -operand_a : operand_a;
    assign b_mag     = b_neg ? -operand_b : operand_b;

    // acc = {product upper, remaining multiplier}; mag holds the multiplicand
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : {(XLEN+1){1'b0}});
    assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

    // acc = {remainder, quotient}; the remainder is widened so the shifted-out MSB is not lost
    assign div_rem_w = acc_q[2*XLEN-1:XLEN-1];
    assign div_trial = div_rem_w - {1'b0, mag_q};
    assign div_step  = div_trial[XLEN] ? {div_rem_w[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign fix_signed = ~op_q[0];
    assign prod_fix   = (fix_signed & qsign_q) ? -acc_q : acc_q;
    assign quot_fix   = (fix_signed & qsign_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix    = (fix_signed & rsign_q) ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0] mul_rest;
    // multiplier bits not yet consumed after this edge's iteration
    assign mul_rest = (acc_q[XLEN-1:0] >> 1) & (({XLEN{1'b1}} >> 1) >> cnt_q);
`endif

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        acc_d         = acc_q;
        mag_d         = mag_q;
        cnt_d         = cnt_q;
        qsign_d       = qsign_q;
        rsign_d       = rsign_q;
        dbz_d         = dbz_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        done_d        = 1'b0;
        div_by_zero_d = div_by_zero_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d          = op;
                    cnt_d         = '0;
                    qsign_d       = a_neg ^ b_neg;
                    rsign_d       = a_neg;
                    div_by_zero_d = 1'b0;
                    dbz_d         = 1'b0;
                    if (op[1] && operand_b == '0) begin
                        acc_d   = {operand_a, {XLEN{1'b0}}};
                        mag_d   = '0;
                        dbz_d   = 1'b1;
                        state_d = S_FIX;
                    end else if (op[1]) begin
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        mag_d   = b_mag;
                        state_d = S_DIV;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, b_mag};
                        mag_d   = a_mag;
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
`ifdef MULDIV_EARLY_OUT_EN
                else if (mul_rest == '0) begin
                    acc_d   = mul_step >> (LAST - cnt_q);
                    state_d = S_FIX;
                end
`endif
            end
            S_DIV: begin
                acc_d = div_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (dbz_q) begin
                    hi_d          = acc_q[2*XLEN-1:XLEN];
                    lo_d          = {XLEN{1'b1}};
                    div_by_zero_d = 1'b1;
                end else if (op_q[1]) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*XLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            acc_q         <= '0;
            mag_q         <= '0;
            cnt_q         <= '0;
            qsign_q       <= 1'b0;
            rsign_q       <= 1'b0;
            dbz_q         <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            acc_q         <= acc_d;
            mag_q         <= mag_d;
            cnt_q         <= cnt_d;
            qsign_q       <= qsign_d;
            rsign_q       <= rsign_d;
            dbz_q         <= dbz_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit (optionally MULDIV_EARLY_OUT_EN)
module tb_muldiv_unit;

    localparam int XLEN = 32;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_M3X7  = 4;
    localparam int LAT_MM1   = 2;
    localparam int LAT_M5X6  = 4;
    localparam int LAT_MX1   = 2;
    localparam int STRAY_E   = 2;
`else
    localparam int LAT_M3X7  = 33;
    localparam int LAT_MM1   = 33;
    localparam int LAT_M5X6  = 33;
    localparam int LAT_MX1   = 33;
    localparam int STRAY_E   = 10;
`endif

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            div_by_zero;

    int passed = 0;
    int total  = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble inputs after acceptance, wait (bounded) for done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit busy_ok, output logic dbz0);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        tick();
        start = 1'b0; op = ~o; operand_a = $urandom; operand_b = $urandom;
        busy_ok = busy;
        dbz0 = div_by_zero;
        lat = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
    endtask

    initial begin
        int  lat;
        bit  bok;
        logic d0;
        int  ndone;
        int  first;

        rst_n = 1'b0; start = 1'b0; op = 2'd0; operand_a = '0; operand_b = '0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // MULT -3 * 7
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, lat, bok, d0);
        chk("mult_m3x7_lat", 64'(lat), 64'(LAT_M3X7));
        chk("mult_m3x7_busy", 64'(bok), 64'd1);
        chk("mult_m3x7_busy_end", 64'(busy), 64'd0);
        chk("mult_m3x7_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_m3x7_lo", 64'(lo), 64'hFFFF_FFEB);

        // MULTU max*max, then MULT of same operands issued in the done cycle
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bok, d0);
        chk("multu_max_lat", 64'(lat), 64'd33);
        chk("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_max_lo", 64'(lo), 64'h0000_0001);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bok, d0);
        chk("mult_m1_lat", 64'(lat), 64'(LAT_MM1));
        chk("mult_m1_hi", 64'(hi), 64'h0);
        chk("mult_m1_lo", 64'(lo), 64'h1);

        // DIV -7 / 2, then done drops and results hold
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, lat, bok, d0);
        chk("div_m7_lat", 64'(lat), 64'd33);
        chk("div_m7_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_m7_hi", 64'(hi), 64'hFFFF_FFFF);
        tick();
        chk("div_m7_done_drop", 64'(done), 64'd0);
        chk("div_m7_lo_hold", 64'(lo), 64'hFFFF_FFFD);

        // DIV MIN_INT / -1 overflow
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok, d0);
        chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
        chk("div_ovf_hi", 64'(hi), 64'h0);
        chk("div_ovf_dbz", 64'(div_by_zero), 64'd0);

        // DIVU by zero, then a normal DIVU clears the flag on acceptance
        run_op(2'd3, 32'd100, 32'd0, lat, bok, d0);
        chk("dbz_lat", 64'(lat), 64'd1);
        chk("dbz_flag", 64'(div_by_zero), 64'd1);
        chk("dbz_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("dbz_hi", 64'(hi), 64'd100);
        tick();
        chk("dbz_flag_hold", 64'(div_by_zero), 64'd1);
        run_op(2'd3, 32'd100, 32'd7, lat, bok, d0);
        chk("divu_flag_clr", 64'(d0), 64'd0);
        chk("divu_lat", 64'(lat), 64'd33);
        chk("divu_lo", 64'(lo), 64'd14);
        chk("divu_hi", 64'(hi), 64'd2);

        // MULTU 5*6 with a stray start while busy
        start = 1'b1; op = 2'd1; operand_a = 32'd5; operand_b = 32'd6;
        tick();
        start = 1'b0;
        ndone = 0; first = 0;
        for (int e = 1; e <= 60; e++) begin
            if (e == STRAY_E) begin
                start = 1'b1; op = 2'd1; operand_a = 32'd9; operand_b = 32'd9;
            end
            tick();
            if (e == STRAY_E) start = 1'b0;
            if (done) begin
                ndone++;
                if (first == 0) first = e;
            end
        end
        chk("stray_ndone", 64'(ndone), 64'd1);
        chk("stray_lat", 64'(first), 64'(LAT_M5X6));
        chk("stray_lo", 64'(lo), 64'd30);
        chk("stray_hi", 64'(hi), 64'd0);

        // Reset in the middle of a DIVU
        start = 1'b1; op = 2'd3; operand_a = 32'd1000; operand_b = 32'd3;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (done) ndone++;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_hi", 64'(hi), 64'd0);
        chk("mid_rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (done) ndone++;
        end
        chk("mid_rst_no_done", 64'(ndone), 64'd0);
        chk("mid_rst_idle", 64'(busy), 64'd0);

        // Multiplier of 1 and a multiplier with the top bit set
        run_op(2'd1, 32'h1234_5678, 32'd1, lat, bok, d0);
        chk("mx1_lat", 64'(lat), 64'(LAT_MX1));
        chk("mx1_lo", 64'(lo), 64'h1234_5678);
        chk("mx1_hi", 64'(hi), 64'h0);
        run_op(2'd1, 32'd3, 32'h8000_0000, lat, bok, d0);
        chk("m3xmsb_lat", 64'(lat), 64'd33);
        chk("m3xmsb_hi", 64'(hi), 64'd1);
        chk("m3xmsb_lo", 64'(lo), 64'h8000_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle iterative multiply/divide unit with HI/LO result registers for the 32-bit MIPS-style core. It is the sequential counterpart of the single-cycle ALU. The execute stage issues MULT/MULTU/DIV/DIVU here through a start/busy/done handshake, and the pipeline stalls on busy. Uses a radix-2 shift-add multiplier and a restoring divider on operand magnitudes, with a final sign-fix cycle.

Parameters:
XLEN, 32, operand and HI/LO width; must be even and >= 8

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  2  0=MULT (signed), 1=MULTU, 2=DIV (signed), 3=DIVU
operand_a  input  XLEN  multiplicand / dividend
operand_b  input  XLEN  multiplier / divisor
busy  output  1  high while an operation is in flight
done  output  1  one-cycle completion pulse
hi  output  XLEN  MUL: upper product half; DIV: remainder
lo  output  XLEN  MUL: lower product half; DIV: quotient
div_by_zero  output  1  set with done when a DIV/DIVU had divisor 0; held until next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0; all internal registers cleared. Reset mid-operation discards the operation with no done pulse.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start=1 at edge E0 latches op and the operands, sets busy=1, and clears div_by_zero.
  - Signed ops store |a| and |b|, plus the result signs: sign_q = a^b; sign_r = a.
  - Next state is MUL or DIV.
  - Divide with operand_b=0 goes straight to FIX.
- MUL: one iteration per edge, XLEN iterations (E1..E_XLEN). Each iteration adds the multiplicand into the upper accumulator if multiplier LSB=1, then shifts the 2*XLEN accumulator right by 1.
- DIV: one restoring step per edge, XLEN steps. Each step:
  - Shift remainder:quotient left by 1.
  - Trial-subtract the divisor; if non-negative, keep the difference and set quotient LSB=1.
- FIX: one edge. Then hi/lo update, done=1 and busy=0 on the same edge, and the state returns to IDLE.
  - Signed MUL: negate the 2*XLEN product if sign_q.
  - Signed DIV: negate the quotient if sign_q; negate the remainder if sign_r.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero: lo = all ones, hi = operand_a unmodified, div_by_zero=1. Done appears at edge E1.
- Fixed latency: done is high in the cycle after edge E_(XLEN+1), i.e. XLEN+1 edges after start acceptance.
- done drops on the following edge. hi/lo hold their value until the next FIX.
- start while busy=1 is ignored; there is no queueing.
- start in the same cycle as done (IDLE already re-entered at that edge) is accepted on the next edge normally.
- Signed overflow: MIN_INT / -1 gives lo=0x80000000, hi=0, with no flag.
- op changes after acceptance have no effect.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: in MUL, if the remaining unshifted multiplier bits are all zero, the state jumps to FIX on that edge, after shifting the accumulator by the remaining count in one step. This gives a variable latency of at most XLEN+1 edges. A multiplier of 0 or 1 completes at E2. DIV is unchanged.
- Undefined: fixed XLEN+1 edge latency for all non-zero-divisor operations; no extra logic is present.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. done exactly 33 edges after start (without MULDIV_EARLY_OUT_EN); busy high throughout.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Same op with MULT -> hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> done at E1, div_by_zero=1, lo=0xFFFFFFFF, hi=100. Next DIVU 100/7 clears the flag and gives lo=14, hi=2.
- Pulse start again at edge 10 of a MULTU 5*6 -> ignored; single done with lo=30. rst_n low at edge 20 of a DIVU -> busy=0, hi=lo=0 immediately; no done.
- With MULDIV_EARLY_OUT_EN: MULTU 0x12345678*1 -> done at E2, lo=0x12345678, hi=0. MULTU 3*0x80000000 -> full 33-edge latency, hi=1, lo=0x80000000.
